// File: rtl/pwm_led_fader.sv
// PWM LED fader: tick-driven 8-bit PWM with static duty or triangle "breathing" level.
// Level/mode only change at the period wrap so a period's waveform is never cut short.

module pwm_led_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mask,
  input  logic on,
  output logic led
);
  always_ff @(posedge clk) begin
    if (rst) led <= 1'b0;
    else     led <= en & mask & on;
  end
endmodule

module pwm_led_fader #(
  parameter int CHANNELS     = 18,
  parameter int STEP_PERIODS = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iTICK,
  input  logic                iEN,
  input  logic                iMODE,
  input  logic                iLOAD,
  input  logic [7:0]          iDUTY,
  input  logic [CHANNELS-1:0] iMASK,
  output logic [CHANNELS-1:0] oLED,
  output logic [7:0]          oLEVEL,
  output logic                oPERIOD_DONE
);
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [1:0] ST_STATIC = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  logic [7:0]    cnt;
  logic [7:0]    shadow;
  logic [7:0]    level;
  logic [SW-1:0] step_cnt;
  logic [1:0]    state;
  logic          wrap;
  logic          last_step;
  logic [7:0]    next_shadow;
  logic          pwm_on;

  assign wrap        = iEN & iTICK & (cnt == 8'hFF);
  assign last_step   = (step_cnt == SW'(STEP_PERIODS - 1));
  // A load landing on the wrap cycle must take effect in the period it opens.
  assign next_shadow = iLOAD ? iDUTY : shadow;
  assign pwm_on      = (cnt < level);
  assign oLEVEL      = level;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt          <= 8'd0;
      shadow       <= 8'd0;
      level        <= 8'd0;
      step_cnt     <= '0;
      state        <= ST_STATIC;
      oPERIOD_DONE <= 1'b0;
    end else begin
      if (iLOAD) shadow <= iDUTY;
      if (iEN && iTICK) cnt <= cnt + 8'd1;
      oPERIOD_DONE <= wrap;
      if (wrap) begin
        case (state)
          ST_STATIC: begin
            if (iMODE) begin
              state    <= ST_RISE;
              step_cnt <= '0;
            end else begin
              level <= next_shadow;
            end
          end
          ST_RISE, ST_FALL: begin
            if (!iMODE) begin
              state    <= ST_STATIC;
              level    <= next_shadow;
              step_cnt <= '0;
            end else if (!last_step) begin
              step_cnt <= step_cnt + SW'(1);
            end else begin
              step_cnt <= '0;
              // Turnarounds clamp so an odd entry level can never wrap past 0/255.
              if (state == ST_RISE) begin
                if (level >= 8'd254) begin
                  level <= 8'd255;
                  state <= ST_FALL;
                end else begin
                  level <= level + 8'd1;
                end
              end else begin
                if (level <= 8'd1) begin
                  level <= 8'd0;
                  state <= ST_RISE;
                end else begin
                  level <= level - 8'd1;
                end
              end
            end
          end
          default: state <= ST_STATIC;
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pwm_led_lane u_lane (
      .clk  (iCLK),
      .rst  (iRST),
      .en   (iEN),
      .mask (iMASK[g]),
      .on   (pwm_on),
      .led  (oLED[g])
    );
  end
endmodule

// File: tb/tb_pwm_led_fader.sv
// Directed bench for pwm_led_fader: reset table, static duty, glitch-free load,
// freeze, mask/edge duties, mid-period reset and the rising/top of the breathe ramp.

module tb_pwm_led_fader;
  localparam int CH = 18;
  localparam logic [CH-1:0] ALL = {CH{1'b1}};

  logic          iCLK = 1'b0;
  logic          iRST, iTICK, iEN, iMODE, iLOAD;
  logic [7:0]    iDUTY;
  logic [CH-1:0] iMASK;
  logic [CH-1:0] oLED;
  logic [7:0]    oLEVEL;
  logic          oPERIOD_DONE;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_led_fader #(.CHANNELS(CH), .STEP_PERIODS(1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iEN(iEN), .iMODE(iMODE),
    .iLOAD(iLOAD), .iDUTY(iDUTY), .iMASK(iMASK),
    .oLED(oLED), .oLEVEL(oLEVEL), .oPERIOD_DONE(oPERIOD_DONE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic          rst, tick, load;
    logic [7:0]    duty;
    logic [CH-1:0] exp_led;
    logic [7:0]    exp_level;
    logic          exp_done;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    do begin
      step();
      k++;
    end while (!oPERIOD_DONE && k < max);
    chk("wait_done", {31'd0, oPERIOD_DONE}, 32'd1);
  endtask

  // hi: samples where every enabled lane is on; lo: samples where all are off.
  task automatic run(input int n, input int load_at, input logic [7:0] load_val,
                     output int hi, output int lo, output int early, output logic last);
    hi = 0; lo = 0; early = 0; last = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (j == load_at) begin
        iLOAD = 1'b1;
        iDUTY = load_val;
      end
      step();
      iLOAD = 1'b0;
      if (oLED == iMASK) hi++;
      else if (oLED == '0) lo++;
      if (j == n - 1) last = oPERIOD_DONE;
      else if (oPERIOD_DONE) early++;
    end
  endtask

  int   hi, lo, early, bad, exp_lvl, prev_lvl;
  logic last;

  initial begin
    iRST = 1'b1; iTICK = 1'b0; iEN = 1'b1; iMODE = 1'b0;
    iLOAD = 1'b0; iDUTY = 8'd0; iMASK = ALL;

    tbl[0] = '{rst:1'b1, tick:1'b1, load:1'b1, duty:8'hAA, exp_led:'0, exp_level:8'd0, exp_done:1'b0};
    tbl[1] = '{rst:1'b1, tick:1'b1, load:1'b0, duty:8'hAA, exp_led:'0, exp_level:8'd0, exp_done:1'b0};
    tbl[2] = '{rst:1'b0, tick:1'b0, load:1'b0, duty:8'h00, exp_led:'0, exp_level:8'd0, exp_done:1'b0};
    tbl[3] = '{rst:1'b0, tick:1'b1, load:1'b1, duty:8'd64, exp_led:'0, exp_level:8'd0, exp_done:1'b0};

    // T1 reset behaviour
    for (int i = 0; i < 4; i++) begin
      iRST = tbl[i].rst; iTICK = tbl[i].tick; iLOAD = tbl[i].load; iDUTY = tbl[i].duty;
      step();
      chk($sformatf("t1_led[%0d]", i),   32'(oLED),         32'(tbl[i].exp_led));
      chk($sformatf("t1_level[%0d]", i), 32'(oLEVEL),       32'(tbl[i].exp_level));
      chk($sformatf("t1_done[%0d]", i),  32'(oPERIOD_DONE), 32'(tbl[i].exp_done));
    end
    iLOAD = 1'b0;

    // T2 static duty 64
    wait_done(300);
    chk("t2_level", 32'(oLEVEL), 32'd64);
    run(256, -1, 8'd0, hi, lo, early, last);
    chk("t2_hi", hi, 64);
    chk("t2_lo", lo, 192);
    chk("t2_early_done", early, 0);
    chk("t2_done", 32'(last), 32'd1);

    // T3 mid-period load waits for the wrap; load on the wrap cycle bypasses
    run(256, 100, 8'd200, hi, lo, early, last);
    chk("t3_hold_hi", hi, 64);
    chk("t3_level200", 32'(oLEVEL), 32'd200);
    run(256, 10, 8'd100, hi, lo, early, last);
    chk("t3_hi200", hi, 200);
    chk("t3_level100", 32'(oLEVEL), 32'd100);
    run(256, 255, 8'd200, hi, lo, early, last);
    chk("t3_hi100", hi, 100);
    chk("t3_bypass", 32'(oLEVEL), 32'd200);
    chk("t3_done", 32'(last), 32'd1);

    // T5 freeze at cnt=37, shadow still loads while frozen
    run(37, -1, 8'd0, hi, lo, early, last);
    chk("t5_pre_hi", hi, 37);
    chk("t5_pre_done", early + 32'(last), 0);
    iEN = 1'b0;
    bad = 0;
    for (int j = 0; j < 1000; j++) begin
      if (j == 500) begin iLOAD = 1'b1; iDUTY = 8'd0; end
      step();
      iLOAD = 1'b0;
      if (oLED != '0 || oPERIOD_DONE) bad++;
    end
    chk("t5_frozen_bad", bad, 0);
    chk("t5_frozen_level", 32'(oLEVEL), 32'd200);
    iEN = 1'b1;
    run(219, -1, 8'd0, hi, lo, early, last);
    chk("t5_resume_hi", hi, 163);
    chk("t5_resume_lo", lo, 56);
    chk("t5_resume_early", early, 0);
    chk("t5_resume_done", 32'(last), 32'd1);
    chk("t5_new_level", 32'(oLEVEL), 32'd0);

    // T6 single-lane mask with duty 0 then 255
    iMASK = 18'h00001;
    run(256, 50, 8'd255, hi, lo, early, last);
    chk("t6_duty0_hi", hi, 0);
    chk("t6_duty0_lo", lo, 256);
    chk("t6_level255", 32'(oLEVEL), 32'd255);
    run(256, -1, 8'd0, hi, lo, early, last);
    chk("t6_duty255_hi", hi, 255);
    chk("t6_duty255_lo", lo, 1);
    chk("t6_done", 32'(last), 32'd1);
    run(100, -1, 8'd0, hi, lo, early, last);
    iRST = 1'b1;
    step();
    chk("t6_rst_led", 32'(oLED), 32'd0);
    chk("t6_rst_level", 32'(oLEVEL), 32'd0);
    chk("t6_rst_done", 32'(oPERIOD_DONE), 32'd0);
    iRST = 1'b0;
    iMASK = ALL;
    run(20, -1, 8'd0, hi, lo, early, last);
    chk("t6_post_rst_hi", hi, 0);

    // T4 breathe from level 0 through the top turnaround
    iMODE = 1'b1;
    wait_done(300);
    chk("t4_enter_level", 32'(oLEVEL), 32'd0);
    prev_lvl = 0;
    for (int p = 1; p <= 262; p++) begin
      exp_lvl = (p <= 255) ? p : 510 - p;
      run(256, -1, 8'd0, hi, lo, early, last);
      chk($sformatf("t4_hi[%0d]", p), hi, prev_lvl);
      chk($sformatf("t4_done[%0d]", p), 32'(last) + 32'(early), 32'd1);
      chk($sformatf("t4_level[%0d]", p), 32'(oLEVEL), exp_lvl);
      prev_lvl = exp_lvl;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
